// File: rtl/rt_sample_unpacker_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rt_sample_unpacker_if                                                      |
// | FIFO read port, sample stream and status counters of the unpacker.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface rt_sample_unpacker_if #(
  parameter int CNT_W = 16
);
  logic             fifo_rd_req;
  logic [15:0]      fifo_rd_data;
  logic             fifo_rd_empty;
  logic             sample_valid;
  logic             sample_ready;
  logic [1:0]       sample_data;
  logic             sample_sof;
  logic [CNT_W-1:0] frame_count;
  logic [7:0]       sync_err_count;
  logic [7:0]       underrun_count;

  modport master (
    output fifo_rd_req,
    input  fifo_rd_data,
    input  fifo_rd_empty,
    output sample_valid,
    input  sample_ready,
    output sample_data,
    output sample_sof,
    output frame_count,
    output sync_err_count,
    output underrun_count
  );

  modport slave (
    input  fifo_rd_req,
    output fifo_rd_data,
    output fifo_rd_empty,
    input  sample_valid,
    output sample_ready,
    input  sample_data,
    input  sample_sof,
    input  frame_count,
    input  sync_err_count,
    input  underrun_count
  );
endinterface
`default_nettype wire

// File: rtl/rt_sample_unpacker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rt_sample_unpacker                                                         |
// | Hunts frame sync, validates length, unpacks 16-bit words to 2-bit samples. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rt_sample_unpacker #(
  parameter logic [15:0] SYNC_WORD   = 16'hA55A,
  parameter int          MAX_PAYLOAD = 256,
  parameter int          CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  rt_sample_unpacker_if.master  bus
);

  localparam int LEN_W = $clog2(MAX_PAYLOAD + 1);

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             run_q;
  logic             rd_inflight_q, rd_inflight_d;
  logic [15:0]      sr_q, sr_d;
  logic [3:0]       sr_cnt_q, sr_cnt_d;
  logic [15:0]      hr_q, hr_d;
  logic             hr_full_q, hr_full_d;
  logic [LEN_W-1:0] pop_left_q, pop_left_d;
  logic [LEN_W-1:0] word_left_q, word_left_d;
  logic             first_q, first_d;
  logic             underrun_q, underrun_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]       sync_err_q, sync_err_d;
  logic [7:0]       underrun_cnt_q, underrun_cnt_d;

  logic rd_req;
  logic xfer;
  logic sr_last;
  logic sr_empty_nxt;
  logic len_ok;
  logic underrun_cond;

  // Only one pop outstanding; run_q keeps the pop low for the first clk after reset release.
  always_comb begin
    rd_req = 1'b0;
    if (run_q && !rd_inflight_q && !bus.fifo_rd_empty) begin
      case (state_q)
        ST_HUNT, ST_LEN: rd_req = 1'b1;
        ST_PAYLOAD:      rd_req = !hr_full_q && (pop_left_q != '0);
        default:         rd_req = 1'b0;
      endcase
    end
  end

  assign xfer          = (sr_cnt_q != 4'd0) && bus.sample_ready;
  assign sr_last       = xfer && (sr_cnt_q == 4'd1);
  assign sr_empty_nxt  = (sr_cnt_q == 4'd0) || sr_last;
  assign len_ok        = (bus.fifo_rd_data != 16'd0) && (bus.fifo_rd_data <= 16'(MAX_PAYLOAD));
  assign underrun_cond = (state_q == ST_PAYLOAD) && (sr_cnt_q == 4'd0) && !hr_full_q &&
                         !rd_inflight_q && bus.fifo_rd_empty;

  always_comb begin
    state_d        = state_q;
    rd_inflight_d  = rd_req;
    sr_d           = sr_q;
    sr_cnt_d       = sr_cnt_q;
    hr_d           = hr_q;
    hr_full_d      = hr_full_q;
    pop_left_d     = pop_left_q;
    word_left_d    = word_left_q;
    first_d        = first_q;
    underrun_d     = underrun_cond;
    frame_cnt_d    = frame_cnt_q;
    sync_err_d     = sync_err_q;
    underrun_cnt_d = underrun_cnt_q;

    if (underrun_cond && !underrun_q && (underrun_cnt_q != 8'hFF)) begin
      underrun_cnt_d = underrun_cnt_q + 8'd1;
    end

    case (state_q)
      ST_HUNT: begin
        if (rd_inflight_q) begin
          if (bus.fifo_rd_data == SYNC_WORD) begin
            state_d = ST_LEN;
          end else if (sync_err_q != 8'hFF) begin
            sync_err_d = sync_err_q + 8'd1;
          end
        end
      end

      ST_LEN: begin
        if (rd_inflight_q) begin
          if (len_ok) begin
            pop_left_d  = bus.fifo_rd_data[LEN_W-1:0];
            word_left_d = bus.fifo_rd_data[LEN_W-1:0];
            first_d     = 1'b1;
            state_d     = ST_PAYLOAD;
          end else begin
            if (sync_err_q != 8'hFF) begin
              sync_err_d = sync_err_q + 8'd1;
            end
            state_d = ST_HUNT;
          end
        end
      end

      ST_PAYLOAD: begin
        if (rd_req) begin
          pop_left_d = pop_left_q - LEN_W'(1);
        end
        if (xfer) begin
          sr_d     = {sr_q[13:0], 2'b00};
          sr_cnt_d = sr_cnt_q - 4'd1;
          first_d  = 1'b0;
        end
        if (sr_last) begin
          word_left_d = word_left_q - LEN_W'(1);
        end
        // Refill in the same clk the last sample leaves so the stream has no bubble.
        if (sr_empty_nxt) begin
          if (hr_full_q) begin
            sr_d      = hr_q;
            sr_cnt_d  = 4'd8;
            hr_full_d = 1'b0;
          end else if (rd_inflight_q) begin
            sr_d     = bus.fifo_rd_data;
            sr_cnt_d = 4'd8;
          end
        end
        if (rd_inflight_q && !(sr_empty_nxt && !hr_full_q)) begin
          hr_d      = bus.fifo_rd_data;
          hr_full_d = 1'b1;
        end
        if (sr_last && (word_left_q == LEN_W'(1))) begin
          frame_cnt_d = frame_cnt_q + CNT_W'(1);
          state_d     = ST_HUNT;
        end
      end

      default: state_d = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_HUNT;
      run_q          <= 1'b0;
      rd_inflight_q  <= 1'b0;
      sr_q           <= '0;
      sr_cnt_q       <= '0;
      hr_q           <= '0;
      hr_full_q      <= 1'b0;
      pop_left_q     <= '0;
      word_left_q    <= '0;
      first_q        <= 1'b0;
      underrun_q     <= 1'b0;
      frame_cnt_q    <= '0;
      sync_err_q     <= '0;
      underrun_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      run_q          <= 1'b1;
      rd_inflight_q  <= rd_inflight_d;
      sr_q           <= sr_d;
      sr_cnt_q       <= sr_cnt_d;
      hr_q           <= hr_d;
      hr_full_q      <= hr_full_d;
      pop_left_q     <= pop_left_d;
      word_left_q    <= word_left_d;
      first_q        <= first_d;
      underrun_q     <= underrun_d;
      frame_cnt_q    <= frame_cnt_d;
      sync_err_q     <= sync_err_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign bus.fifo_rd_req    = rd_req;
  assign bus.sample_valid   = (sr_cnt_q != 4'd0);
  assign bus.sample_data    = sr_q[15:14];
  assign bus.sample_sof     = first_q && (sr_cnt_q != 4'd0);
  assign bus.frame_count    = frame_cnt_q;
  assign bus.sync_err_count = sync_err_q;
  assign bus.underrun_count = underrun_cnt_q;

endmodule
`default_nettype wire
